// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between ifmap/weight readers and the compressor
// writer, routing read responses back in issue order. Define MEM_ARB_STATS_EN for grant/stall stats.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned MAX_OUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        ifmap_base,
  input  logic [ADDR_W-1:0]        weight_base,
  input  logic [ADDR_W-1:0]        comp_base,
  input  logic [2:0]               req,
  input  logic [DATA_W-1:0]        comp_wdata,
  output logic [2:0]               ack,
  output logic                     mem_valid,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [1:0]               rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]              gnt_cnt0,
  output logic [31:0]              gnt_cnt1,
  output logic [31:0]              gnt_cnt2,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(MAX_OUT);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUT);

  logic [1:0]        last_q;
  logic [ADDR_W-1:0] addr_q [3];
  logic [MAX_OUT-1:0] tags_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   out_q;
  logic              err_q;

  logic [2:0] eligible;
  logic       can_read;
  logic [1:0] o0, o1, o2;
  logic [1:0] win;
  logic       grant;
  logic       push, pop, tag_out;

  // Search order starts just after the last winner.
  always_comb begin
    can_read = (out_q < MaxOut);
    eligible = req & {1'b1, can_read, can_read} & {3{~start}};
    case (last_q)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (eligible[o0])      win = o0;
    else if (eligible[o1]) win = o1;
    else                   win = o2;
  end

  always_comb begin
    mem_valid = |eligible;
    grant     = mem_valid & mem_ready;
    mem_we    = mem_valid & (win == 2'd2);
    mem_addr  = '0;
    if (mem_valid) begin
      case (win)
        2'd0:    mem_addr = addr_q[0];
        2'd1:    mem_addr = addr_q[1];
        default: mem_addr = addr_q[2];
      endcase
    end
    ack = grant ? (3'b001 << win) : 3'b000;
  end

  assign mem_wdata = comp_wdata;
  assign push      = ack[0] | ack[1];
  assign pop       = mem_rvalid & (out_q != '0);
  assign tag_out   = tags_q[rd_ptr_q];

  always_comb begin
    rsp_valid = 2'b00;
    if (pop) rsp_valid = tag_out ? 2'b10 : 2'b01;
  end

  assign rsp_data    = mem_rdata;
  assign outstanding = out_q;
  assign err         = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 2'd2;
      addr_q[0] <= '0;
      addr_q[1] <= '0;
      addr_q[2] <= '0;
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_q    <= '0;
    end else if (start) begin
      last_q    <= 2'd2;
      addr_q[0] <= ifmap_base;
      addr_q[1] <= weight_base;
      addr_q[2] <= comp_base;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_q     <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ack[i]) addr_q[i] <= addr_q[i] + ADDR_W'(1);
      end
      if (grant) last_q <= win;
      if (push) begin
        tags_q[wr_ptr_q] <= ack[1];
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   out_q <= out_q + CntW'(1);
        2'b01:   out_q <= out_q - CntW'(1);
        default: out_q <= out_q;
      endcase
    end
  end

  // Sticky: stray response, or flush while reads are still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((mem_rvalid && out_q == '0) || (start && out_q != '0)) begin
      err_q <= 1'b1;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] gnt_cnt_q [3];
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt_q[0] <= '0;
      gnt_cnt_q[1] <= '0;
      gnt_cnt_q[2] <= '0;
      stall_cnt_q  <= '0;
    end else if (start) begin
      gnt_cnt_q[0] <= '0;
      gnt_cnt_q[1] <= '0;
      gnt_cnt_q[2] <= '0;
      stall_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ack[i] && gnt_cnt_q[i] != '1) gnt_cnt_q[i] <= gnt_cnt_q[i] + 32'd1;
      end
      if (mem_valid && !mem_ready && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign gnt_cnt0  = gnt_cnt_q[0];
  assign gnt_cnt1  = gnt_cnt_q[1];
  assign gnt_cnt2  = gnt_cnt_q[2];
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin order, address counters, tag routing,
// outstanding limit, error flag and flush behaviour with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned MAX_OUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] ifmap_base, weight_base, comp_base;
  logic [2:0]        req;
  logic [DATA_W-1:0] comp_wdata;
  logic [2:0]        ack;
  logic              mem_valid, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready, mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [$clog2(MAX_OUT):0] outstanding;
  logic              err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ifmap_base (ifmap_base),
    .weight_base(weight_base),
    .comp_base  (comp_base),
    .req        (req),
    .comp_wdata (comp_wdata),
    .ack        (ack),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .outstanding(outstanding),
    .err        (err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin table: all three requesting, reads answered two cycles after issue.
  logic [2:0]  t_req [8] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000};
  logic        t_rv  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [2:0]  t_ack [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
  logic [31:0] t_adr [8] = '{32'h100, 32'h200, 32'h300, 32'h101, 32'h201, 32'h301, 32'h0, 32'h0};
  logic [1:0]  t_rsp [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};

  logic [1:0] ord_rsp [3] = '{2'b10, 2'b01, 2'b10};

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    req         = 3'b000;
    mem_ready   = 1'b1;
    mem_rvalid  = 1'b0;
    ifmap_base  = 32'h100;
    weight_base = 32'h200;
    comp_base   = 32'h300;
    comp_wdata  = {192'd0, 64'h0000_0000_0000_ABCD};
    mem_rdata   = {192'd0, 64'h1234_5678_9ABC_DEF0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 64'(ack), 64'h0);
    check("rst_mem_valid", 64'(mem_valid), 64'h0);
    check("rst_mem_we", 64'(mem_we), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_outstanding", 64'(outstanding), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    rst_n = 1'b1;
    tick();

    // Start cycle grants nothing even with every request up.
    start = 1'b1;
    req   = 3'b111;
    #1;
    check("start_no_valid", 64'(mem_valid), 64'h0);
    check("start_no_ack", 64'(ack), 64'h0);
    tick();
    start = 1'b0;

    for (int c = 0; c < 8; c++) begin
      req        = t_req[c];
      mem_rvalid = t_rv[c];
      #1;
      check($sformatf("rr_ack_%0d", c), 64'(ack), 64'(t_ack[c]));
      check($sformatf("rr_addr_%0d", c), 64'(mem_addr), 64'(t_adr[c]));
      check($sformatf("rr_we_%0d", c), 64'(mem_we), 64'(t_ack[c] == 3'b100));
      check($sformatf("rr_rsp_%0d", c), 64'(rsp_valid), 64'(t_rsp[c]));
      if (c == 2) begin
        check("rsp_data", rsp_data[63:0], 64'h1234_5678_9ABC_DEF0);
        check("mem_wdata", mem_wdata[63:0], 64'hABCD);
      end
      tick();
    end
    req        = 3'b000;
    mem_rvalid = 1'b0;
    check("rr_outstanding_end", 64'(outstanding), 64'h0);
    check("rr_err_clean", 64'(err), 64'h0);

    // Stray response with nothing in flight.
    mem_rvalid = 1'b1;
    #1;
    check("stray_rsp", 64'(rsp_valid), 64'h0);
    tick();
    mem_rvalid = 1'b0;
    check("stray_err", 64'(err), 64'h1);
    check("stray_outstanding", 64'(outstanding), 64'h0);
    tick();
    tick();
    check("err_sticky", 64'(err), 64'h1);

    // Only reset clears err; counters return to zero.
    rst_n = 1'b0;
    #1;
    check("rst2_err", 64'(err), 64'h0);
    check("rst2_outstanding", 64'(outstanding), 64'h0);
    rst_n = 1'b1;
    req   = 3'b001;
    #1;
    check("rst2_addr_zero", 64'(mem_addr), 64'h0);
    req = 3'b000;
    tick();

    comp_base = 32'hFFFF_FFFF;
    start     = 1'b1;
    tick();
    start = 1'b0;

    for (int i = 0; i < 3; i++) begin
      req = 3'b001;
      #1;
      check($sformatf("ifm_ack_%0d", i), 64'(ack), 64'h1);
      check($sformatf("ifm_addr_%0d", i), 64'(mem_addr), 64'(32'h100 + i));
      check($sformatf("ifm_we_%0d", i), 64'(mem_we), 64'h0);
      tick();
      check($sformatf("ifm_out_%0d", i), 64'(outstanding), 64'(i + 1));
    end

    repeat (13) begin
      req = 3'b001;
      tick();
    end
    check("full_outstanding", 64'(outstanding), 64'd16);
    req = 3'b001;
    #1;
    check("full_rd_ack", 64'(ack), 64'h0);
    check("full_rd_valid", 64'(mem_valid), 64'h0);
    req = 3'b101;
    #1;
    check("full_wr_ack", 64'(ack), 64'h4);
    check("full_wr_we", 64'(mem_we), 64'h1);
    check("wr_addr_max", 64'(mem_addr), 64'hFFFF_FFFF);
    tick();
    req = 3'b100;
    #1;
    check("wr_addr_wrap", 64'(mem_addr), 64'h0);
    req = 3'b000;
    check("full_still_16", 64'(outstanding), 64'd16);
    tick();

    for (int i = 0; i < 16; i++) begin
      mem_rvalid = 1'b1;
      #1;
      check($sformatf("drain_rsp_%0d", i), 64'(rsp_valid), 64'h1);
      tick();
    end
    mem_rvalid = 1'b0;
    check("drain_outstanding", 64'(outstanding), 64'h0);

    // mem_ready low: request shown but nothing advances.
    req       = 3'b010;
    mem_ready = 1'b0;
    #1;
    check("stall_valid", 64'(mem_valid), 64'h1);
    check("stall_ack", 64'(ack), 64'h0);
    tick();
    check("stall_outstanding", 64'(outstanding), 64'h0);
    mem_ready = 1'b1;
    #1;
    check("stall_addr_held", 64'(mem_addr), 64'h200);
    tick();
    req = 3'b001;
    #1;
    check("ord_ifm_addr", 64'(mem_addr), 64'h110);
    tick();
    req = 3'b010;
    #1;
    check("ord_w_addr", 64'(mem_addr), 64'h201);
    tick();
    req = 3'b000;
    check("ord_outstanding", 64'(outstanding), 64'd3);
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      #1;
      check($sformatf("ord_rsp_%0d", i), 64'(rsp_valid), 64'(ord_rsp[i]));
      tick();
    end
    mem_rvalid = 1'b0;
    check("ord_outstanding_end", 64'(outstanding), 64'h0);
    check("ord_err_clean", 64'(err), 64'h0);

    // Flush with two reads in flight.
    req = 3'b011;
    tick();
    tick();
    req = 3'b000;
    check("flush_pre_out", 64'(outstanding), 64'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("flush_err", 64'(err), 64'h1);
    check("flush_outstanding", 64'(outstanding), 64'h0);
    mem_rvalid = 1'b1;
    #1;
    check("flush_stray_rsp", 64'(rsp_valid), 64'h0);
    tick();
    mem_rvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
